regbank_write_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single write port of a small register bank between NUM_REQ requesters.
- The register bank is NUM_WORDS words of DATA_W enable flip-flops, one enable per word.
- The block selects a winner, drives the one-hot word enable plus write data for exactly one cycle, and acknowledges the winning requester.
- Sits between requester logic and the register bank.

---
 rtl/regbank_write_arbiter_pkg.sv | 19 +
 rtl/regbank_write_arbiter_rr_pick.sv | 26 ++
 rtl/regbank_write_arbiter.sv | 115 +++++++++++
 tb/tb_regbank_write_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regbank_write_arbiter_pkg.sv
// rtl/regbank_write_arbiter_pkg.sv - shared state encodings, default widths and helpers for the register bank write arbiter
package regbank_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_WORDS = 4;
    localparam int DEF_ADDR_W    = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rtl/regbank_write_arbiter_rr_pick.sv - combinational round-robin picker starting its search at ptr
module rr_pick
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Walk from the farthest offset down to ptr so the closest requester at or after ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % NUM_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin sequencer for the shared register bank write port; REGARB_LOCK_EN adds per-requester lock
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef REGARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_flat,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_flat,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_WORDS-1:0]      word_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy,
    output logic                      err_addr
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [ADDR_W:0] NUM_WORDS_C = (ADDR_W + 1)'(NUM_WORDS);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic              is_write;
    logic              addr_ok;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign is_write = (state_q == ST_WRITE);
    assign addr_ok  = ({1'b0, addr_q} < NUM_WORDS_C);
    assign next_ptr = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    assign busy     = is_write;
    assign wr_data  = data_q;
    assign err_addr = is_write & ~addr_ok;

    // Capture the winner's request in IDLE; in WRITE advance (or hold) the pointer and return.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    addr_d   = addr_flat[int'(pick_idx) * ADDR_W +: ADDR_W];
                    data_d   = wdata_flat[int'(pick_idx) * DATA_W +: DATA_W];
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                rr_ptr_d = next_ptr;
`ifdef REGARB_LOCK_EN
                if (lock[winner_q]) begin
                    rr_ptr_d = winner_q;
                end
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded strobes: async reset clears state_q, so ack/word_en drop the instant rst rises.
    always_comb begin
        ack     = '0;
        word_en = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            ack[r] = is_write & (winner_q == IDX_W'(r));
        end
        for (int w = 0; w < NUM_WORDS; w++) begin
            word_en[w] = is_write & addr_ok & (addr_q == ADDR_W'(w));
        end
    end

    // Arbiter state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - directed self-checking bench for regbank_write_arbiter (4-word and 3-word instances)
module tb_regbank_write_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] addr_flat;
    logic [31:0] wdata_flat;
`ifdef REGARB_LOCK_EN
    logic [3:0] lock;
`endif
    logic [3:0] ack, ack3;
    logic [3:0] word_en;
    logic [2:0] word_en3;
    logic [7:0] wr_data, wr_data3;
    logic       busy, busy3;
    logic       err_addr, err_addr3;

    int n_chk;
    int n_err;

    regbank_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
`ifdef REGARB_LOCK_EN
        .lock       (lock),
`endif
        .req        (req),
        .addr_flat  (addr_flat),
        .wdata_flat (wdata_flat),
        .ack        (ack),
        .word_en    (word_en),
        .wr_data    (wr_data),
        .busy       (busy),
        .err_addr   (err_addr)
    );

    regbank_write_arbiter #(.NUM_WORDS(3)) dut_w3 (
        .clk        (clk),
        .rst        (rst),
`ifdef REGARB_LOCK_EN
        .lock       (lock),
`endif
        .req        (req),
        .addr_flat  (addr_flat),
        .wdata_flat (wdata_flat),
        .ack        (ack3),
        .word_en    (word_en3),
        .wr_data    (wr_data3),
        .busy       (busy3),
        .err_addr   (err_addr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [1:0] a, input logic [7:0] d);
        addr_flat[i*2 +: 2]  = a;
        wdata_flat[i*8 +: 8] = d;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        req = '0;
        addr_flat = '0;
        wdata_flat = '0;
`ifdef REGARB_LOCK_EN
        lock = '0;
`endif
        tick();
        tick();
        check("rst_ack", 32'(ack), 0);
        check("rst_word_en", 32'(word_en), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_addr), 0);
        rst = 1'b0;

        // single request from requester 1
        set_src(1, 2'd2, 8'hA5);
        req = 4'b0010;
        tick();
        check("t1_ack", 32'(ack), 32'h2);
        check("t1_word_en", 32'(word_en), 32'h4);
        check("t1_wr_data", 32'(wr_data), 32'hA5);
        check("t1_busy", 32'(busy), 1);
        check("t1_err", 32'(err_addr), 0);
        req = '0;
        tick();
        check("t1_ack_off", 32'(ack), 0);
        check("t1_word_en_off", 32'(word_en), 0);
        check("t1_busy_off", 32'(busy), 0);
        tick();
        check("t1_idle_ack", 32'(ack), 0);

        // rr_ptr is 2: requester 2 must beat requester 0
        set_src(0, 2'd0, 8'h11);
        set_src(2, 2'd1, 8'h33);
        req = 4'b0101;
        tick();
        check("ptr2_ack", 32'(ack), 32'h4);
        check("ptr2_word_en", 32'(word_en), 32'h2);
        check("ptr2_wr_data", 32'(wr_data), 32'h33);
        req = '0;
        tick();

        // pointer now 3: wrap 3 then 0; address 3 is out of range for the 3-word instance
        set_src(3, 2'd3, 8'h44);
        req = 4'b1001;
        tick();
        check("wrap_ack3", 32'(ack), 32'h8);
        check("wrap_word_en3", 32'(word_en), 32'h8);
        check("bad_ack", 32'(ack3), 32'h8);
        check("bad_word_en", 32'(word_en3), 0);
        check("bad_err", 32'(err_addr3), 1);
        check("good_err", 32'(err_addr), 0);
        tick();
        check("bad_err_off", 32'(err_addr3), 0);
        check("wrap_gap", 32'(ack), 0);
        tick();
        check("wrap_ack0", 32'(ack), 32'h1);
        check("wrap_word_en0", 32'(word_en), 32'h1);
        check("wrap_wr_data0", 32'(wr_data), 32'h11);
        req = '0;
        tick();

        // all requesting from reset: grants 0,1,2,3,0 one every 2 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 2'(i), 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("all_ack", 32'(ack), 32'(1 << (k % 4)));
            check("all_word_en", 32'(word_en), 32'(1 << (k % 4)));
            check("all_wr_data", 32'(wr_data), 32'(8'h10 + (k % 4)));
            check("all_err3", 32'(err_addr3), ((k % 4) == 3) ? 1 : 0);
            tick();
            check("all_gap", 32'(ack), 0);
        end
        req = '0;

        // reset during the WRITE cycle of requester 1
        req = 4'b0010;
        tick();
        check("rmw_ack_pre", 32'(ack), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("rmw_ack", 32'(ack), 0);
        check("rmw_word_en", 32'(word_en), 0);
        check("rmw_busy", 32'(busy), 0);
        tick();
        check("rmw_hold_ack", 32'(ack), 0);
        check("rmw_hold_word_en", 32'(word_en), 0);
        #2;
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("rmw_ptr0", 32'(ack), 32'h1);
        req = '0;
        tick();

`ifdef REGARB_LOCK_EN
        // locked requester 0 keeps winning; releasing lock passes the grant to 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lock = 4'b0001;
        req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("lock_ack0", 32'(ack), 32'h1);
            if (k == 2) lock = '0;
            tick();
        end
        tick();
        check("unlock_ack1", 32'(ack), 32'h2);
        req = '0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
